// File: rtl/micro_control_decoder_pkg.sv
// micro_control_decoder_pkg: shared step codes, register/bus constants, control word and decode table
//   Imported by the decoder and its testbench-facing interface users.
//   decode(code) is a pure function: step code -> control word + halt/illegal flags.
package micro_control_decoder_pkg;
   localparam int NREG  = 8;
   localparam int BUS_W = 4;
   localparam int ALU_W = 4;
   localparam logic [5:0] FETCH1    = 6'd1;
   localparam logic [5:0] FETCH2    = 6'd2;
   localparam logic [5:0] FETCH3    = 6'd3;
   localparam logic [5:0] XFER_BASE = 6'd4;
   localparam logic [5:0] ALU_BASE  = 6'd36;
   localparam logic [5:0] JMP_ADDR  = 6'd52;
   localparam logic [5:0] JMP_LOAD  = 6'd53;
   localparam logic [5:0] JMP_SKIP  = 6'd54;
   localparam logic [5:0] CLR_AC    = 6'd55;
   localparam logic [5:0] NOP       = 6'd56;
   localparam logic [5:0] HALT      = 6'd57;
   localparam logic [5:0] MOV_AC_DR = 6'd58;
   localparam logic [5:0] MOV_DR_AC = 6'd59;
   localparam logic [2:0] R_PC = 3'd0;
   localparam logic [2:0] R_AR = 3'd1;
   localparam logic [2:0] R_DR = 3'd2;
   localparam logic [2:0] R_IR = 3'd3;
   localparam logic [2:0] R_AC = 3'd4;
   localparam logic [2:0] R_B  = 3'd5;
   localparam logic [2:0] R_C  = 3'd6;
   localparam logic [2:0] R_SP = 3'd7;
   localparam logic [BUS_W-1:0] BUS_NONE = 4'd0;
   localparam logic [BUS_W-1:0] BUS_MEM  = 4'd1;
   localparam logic [BUS_W-1:0] BUS_ALU  = 4'd2;
   localparam logic [BUS_W-1:0] BUS_REG  = 4'd8;
   typedef struct packed {
      logic [BUS_W-1:0] bus_sel;
      logic [NREG-1:0]  reg_ld;
      logic             pc_inc;
      logic [ALU_W-1:0] alu_op;
      logic             mem_req;
      logic             mem_we;
      logic             alu_step;
      logic             clr_z;
   } ctrl_word_t;
   typedef struct packed {
      ctrl_word_t word;
      logic       halt;
      logic       illegal;
   } decode_t;
   localparam ctrl_word_t NOP_WORD = '0;
   // Every register drives the bus at BUS_REG + its index.
   function automatic logic [BUS_W-1:0] bus_of(input logic [2:0] r);
      return BUS_REG | {1'b0, r};
   endfunction
   function automatic logic [NREG-1:0] ld_of(input logic [2:0] r);
      return NREG'(1) << r;
   endfunction
   // Codes 4..35 form four groups of eight, indexed by register r:
   //   4..11 DR->r, 12..19 r->AR, 20..27 mem read into r, 28..35 mem write from r.
   function automatic decode_t decode(input logic [5:0] code);
      decode_t d;
      logic [4:0] k;
      d = '0;
      k = 5'(code - XFER_BASE);
      if (code == 6'd0 || code > MOV_DR_AC) d.illegal = 1'b1;
      else if (code == FETCH1 || code == JMP_ADDR) begin
         d.word.bus_sel = bus_of(R_PC);
         d.word.reg_ld  = ld_of(R_AR);
      end
      else if (code == FETCH2) begin
         d.word.mem_req = 1'b1;
         d.word.pc_inc  = 1'b1;
      end
      else if (code == FETCH3) begin
         d.word.bus_sel = BUS_MEM;
         d.word.reg_ld  = ld_of(R_IR);
      end
      else if (code < ALU_BASE) begin
         d.word.bus_sel = k[4:3] == 2'd0 ? bus_of(R_DR) : k[4:3] == 2'd2 ? BUS_MEM : bus_of(k[2:0]);
         d.word.reg_ld  = k[4:3] == 2'd1 ? ld_of(R_AR) : k[4:3] == 2'd3 ? '0 : ld_of(k[2:0]);
         d.word.mem_req = k[4];
         d.word.mem_we  = k[4] & k[3];
      end
      else if (code < JMP_ADDR) begin
         d.word.alu_op   = ALU_W'(code - ALU_BASE);
         d.word.bus_sel  = BUS_ALU;
         d.word.reg_ld   = ld_of(R_AC);
         d.word.alu_step = 1'b1;
      end
      else if (code == JMP_LOAD) begin
         d.word.bus_sel = bus_of(R_DR);
         d.word.reg_ld  = ld_of(R_PC);
      end
      else if (code == JMP_SKIP) d.word.pc_inc = 1'b1;
      // An idle bus reads as zero, so loading AC from it clears AC.
      else if (code == CLR_AC) begin
         d.word.reg_ld = ld_of(R_AC);
         d.word.clr_z  = 1'b1;
      end
      else if (code == HALT) d.halt = 1'b1;
      else if (code == MOV_AC_DR) begin
         d.word.bus_sel = bus_of(R_AC);
         d.word.reg_ld  = ld_of(R_DR);
      end
      else if (code == MOV_DR_AC) begin
         d.word.bus_sel = bus_of(R_DR);
         d.word.reg_ld  = ld_of(R_AC);
      end
      return d;
   endfunction
endpackage

// File: rtl/micro_control_decoder_if.sv
// micro_control_decoder_if: sequencer/datapath-facing signals of the micro control decoder
//   master: drives sm_in, alu_zero, mem_ack; observes the control word and status.
//   slave : the decoder side.
interface micro_control_decoder_if #(
   parameter int REG_CNT   = 8,
   parameter int BUS_SEL_W = 4,
   parameter int ALU_OP_W  = 4
);
   logic [5:0]           sm_in;
   logic                 alu_zero;
   logic                 mem_ack;
   logic [BUS_SEL_W-1:0] bus_sel;
   logic [REG_CNT-1:0]   reg_ld;
   logic                 pc_inc;
   logic [ALU_OP_W-1:0]  alu_op;
   logic                 mem_req;
   logic                 mem_we;
   logic                 stall;
   logic                 z_out;
   logic                 halted;
   logic                 illegal;
   modport master (
      output sm_in, alu_zero, mem_ack,
      input  bus_sel, reg_ld, pc_inc, alu_op, mem_req, mem_we, stall, z_out, halted, illegal
   );
   modport slave (
      input  sm_in, alu_zero, mem_ack,
      output bus_sel, reg_ld, pc_inc, alu_op, mem_req, mem_we, stall, z_out, halted, illegal
   );
endinterface

// File: rtl/micro_control_decoder_zflag_reg.sv
// micro_control_decoder_zflag_reg: Z flag register
//   clk, rst   : clock, async active-high reset (Z cleared)
//   alu_step_i : applied word is an ALU step -> capture alu_zero_i
//   clr_i      : applied word clears AC -> Z set
//   z_o        : Z flag
module micro_control_decoder_zflag_reg (
   input  logic clk,
   input  logic rst,
   input  logic alu_step_i,
   input  logic clr_i,
   input  logic alu_zero_i,
   output logic z_o
);
   logic z_q, z_d;
   assign z_d = clr_i ? 1'b1 : alu_step_i ? alu_zero_i : z_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) z_q <= 1'b0;
      else     z_q <= z_d;
   assign z_o = z_q;
endmodule

// File: rtl/micro_control_decoder.sv
// micro_control_decoder: registered control word for the datapath from sequencer step codes
//   clk, rst : clock, async active-high reset
//   bus      : slave side of micro_control_decoder_if (sm_in/alu_zero/mem_ack in,
//              control word, stall, z_out, halted, illegal out)
module micro_control_decoder
   import micro_control_decoder_pkg::*;
#(
   parameter int REG_CNT   = NREG,
   parameter int BUS_SEL_W = BUS_W,
   parameter int ALU_OP_W  = ALU_W
) (
   input logic clk,
   input logic rst,
   micro_control_decoder_if.slave bus
);
   ctrl_word_t word_q, word_d;
   logic       halted_q, halted_d, illegal_q, illegal_d, sample;
   decode_t    dec;
   assign dec       = decode(bus.sm_in);
   assign bus.stall = word_q.mem_req & ~bus.mem_ack;
   // Halt leaves NOP in the word register, so stall stays low once halted.
   assign sample    = ~bus.stall & ~halted_q;
   always_comb begin
      word_d    = sample ? dec.word : word_q;
      halted_d  = halted_q | (sample & dec.halt);
      illegal_d = illegal_q | (sample & dec.illegal);
      assert ($onehot0(dec.word.reg_ld));
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         word_q    <= NOP_WORD;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         word_q    <= word_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
      end
   micro_control_decoder_zflag_reg u_zflag (
      .clk        (clk),
      .rst        (rst),
      .alu_step_i (word_q.alu_step),
      .clr_i      (word_q.clr_z),
      .alu_zero_i (bus.alu_zero),
      .z_o        (bus.z_out)
   );
   assign bus.bus_sel = BUS_SEL_W'(word_q.bus_sel);
   assign bus.reg_ld  = REG_CNT'(word_q.reg_ld);
   assign bus.pc_inc  = word_q.pc_inc;
   assign bus.alu_op  = ALU_OP_W'(word_q.alu_op);
   assign bus.mem_req = word_q.mem_req;
   assign bus.mem_we  = word_q.mem_we;
   assign bus.halted  = halted_q;
   assign bus.illegal = illegal_q;
endmodule
